// File: rtl/io_channel_unit_pkg.sv
// Shared types and default sizing for the I/O channel responder.
package io_channel_unit_pkg;
    localparam int NUM_CH_DEF     = 16;
    localparam int WIDTH_DEF      = 15;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CW_DEF         = $clog2(NUM_CH_DEF);

    typedef logic [WIDTH_DEF-1:0] word_t;
    typedef logic [CW_DEF-1:0]    chan_t;

    typedef struct packed {
        chan_t chan;
        word_t data;
    } out_ent_t;
endpackage

// File: rtl/io_fifo.sv
// Small power-of-two FIFO with occupancy count; head is read straight from storage.
module io_fifo #(
    parameter int DW    = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/io_channel_unit.sv
// I/O channel register file with same-cycle read bypass and an output FIFO
// forwarding every accepted pipeline write to the external device.
module io_channel_unit
    import io_channel_unit_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CW         = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             io_wr_en,
    input  logic             io_rd_en,
    input  logic [CW-1:0]    chan,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             overflow,
    input  logic             in_valid,
    input  logic [CW-1:0]    in_chan,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_chan,
    output logic [WIDTH-1:0] out_data
);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    logic [WIDTH-1:0]    regs [NUM_CH];
    logic [WIDTH-1:0]    rd_byp;
    logic                wr_acc;
    logic                fifo_full, fifo_empty;
    logic [CNTW-1:0]     fifo_count;
    logic [CW+WIDTH-1:0] fifo_dout;

    // Acceptance looks only at registered state, so a same-cycle pop never unblocks a write.
    assign wr_acc    = io_wr_en && !fifo_full;
    assign busy      = (fifo_count == CNTW'(FIFO_DEPTH));
    assign out_valid = !fifo_empty;
    assign {out_chan, out_data} = fifo_dout;

    io_fifo #(.DW(CW + WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_acc),
        .pop   (out_ready),
        .din   ({chan, wr_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rd_byp = regs[chan];
        if (in_valid && in_chan == chan)
            rd_byp = in_data;
        if (wr_acc)
            rd_byp = wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_acc && chan == CW'(i))
                    regs[i] <= wr_data;
                else if (in_valid && in_chan == CW'(i))
                    regs[i] <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_valid <= io_rd_en;
            if (io_rd_en)
                rd_data <= rd_byp;
            if (io_wr_en && busy)
                overflow <= 1'b1;
        end
    end
endmodule
